// File: rtl/wb_sram_slave.sv
// Wishbone pipelined slave driving an asynchronous 16-bit SRAM: each 32-bit access is two 16-bit
// cycles with WAIT_STATES extra cycles each. Optional WB_SRAM_LANE_SKIP_EN skips halves with no lanes.
module wb_sram_slave #(
   parameter int unsigned ADDR_W      = 20,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // Slave side of the if_wb bus
   input  logic              bus_cyc,
   input  logic              bus_stb,
   input  logic              bus_we,
   input  logic [3:0]        bus_sel,
   input  logic [31:0]       bus_adr,
   input  logic [31:0]       bus_dat_i,
   output logic [31:0]       bus_dat_o,
   output logic              bus_ack,
   output logic              bus_stall,
   // SRAM side
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_o,
   input  logic [15:0]       sram_dq_i,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_ub_n,
   output logic              sram_lb_n
);

`ifdef WB_SRAM_LANE_SKIP_EN
   localparam bit LaneSkip = 1'b1;
`else
   localparam bit LaneSkip = 1'b0;
`endif

   localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      StIdle,
      StLo,
      StLoRec,
      StHi,
      StHiRec,
      StAck
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-2:0]  adr_q, adr_d;
   logic               we_q, we_d;
   logic [3:0]         sel_q, sel_d;
   logic [31:0]        wdat_q, wdat_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [31:0]        dat_q, dat_d;

   logic               acc_lo_skip, acc_hi_skip, hi_skip;
   logic               cnt_done;
   logic               in_lo, in_hi;
   logic               unused_adr;

   assign unused_adr  = ^{bus_adr[31:ADDR_W+1], bus_adr[1:0]};

   assign acc_lo_skip = LaneSkip && (bus_sel[1:0] == 2'b00);
   assign acc_hi_skip = LaneSkip && (bus_sel[3:2] == 2'b00);
   assign hi_skip     = LaneSkip && (sel_q[3:2] == 2'b00);
   assign cnt_done    = (cnt_q == 4'd0);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      we_d    = we_q;
      sel_d   = sel_q;
      wdat_d  = wdat_q;
      cnt_d   = cnt_q;
      dat_d   = dat_q;

      unique case (state_q)
         StIdle: begin
            if (bus_cyc && bus_stb) begin
               adr_d  = bus_adr[ADDR_W:2];
               we_d   = bus_we;
               sel_d  = bus_sel;
               wdat_d = bus_dat_i;
               cnt_d  = WaitLoad;
               dat_d  = '0;
               if (!acc_lo_skip) begin
                  state_d = StLo;
               end else if (!acc_hi_skip) begin
                  state_d = StHi;
               end else begin
                  state_d = StAck;
               end
            end
         end
         StLo: begin
            if (cnt_done) begin
               cnt_d = WaitLoad;
               if (we_q) begin
                  state_d = StLoRec;
               end else begin
                  dat_d[15:0] = sram_dq_i;
                  state_d     = hi_skip ? StAck : StHi;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StLoRec: begin
            state_d = hi_skip ? StAck : StHi;
         end
         StHi: begin
            if (cnt_done) begin
               if (we_q) begin
                  state_d = StHiRec;
               end else begin
                  dat_d[31:16] = sram_dq_i;
                  state_d      = StAck;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StHiRec: begin
            state_d = StAck;
         end
         StAck: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Master dropped cyc: abandon the access without an ack
      if ((state_q != StIdle) && !bus_cyc) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         adr_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wdat_q  <= '0;
         cnt_q   <= '0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         wdat_q  <= wdat_d;
         cnt_q   <= cnt_d;
         dat_q   <= dat_d;
      end
   end

   assign in_lo = (state_q == StLo) || (state_q == StLoRec);
   assign in_hi = (state_q == StHi) || (state_q == StHiRec);

   // Bus and SRAM outputs, decoded from state
   always_comb begin
      bus_ack    = (state_q == StAck);
      bus_stall  = (state_q != StIdle);
      bus_dat_o  = dat_q;
      sram_addr  = '0;
      sram_dq_o  = '0;
      sram_dq_oe = 1'b0;
      sram_ce_n  = 1'b1;
      sram_oe_n  = 1'b1;
      sram_we_n  = 1'b1;
      sram_ub_n  = 1'b1;
      sram_lb_n  = 1'b1;

      if (in_lo || in_hi) begin
         sram_addr = {adr_q, in_hi};
         sram_ce_n = 1'b0;
         if (we_q) begin
            // REC states keep address, data and lanes stable with we_n released
            sram_dq_oe = 1'b1;
            sram_we_n  = !((state_q == StLo) || (state_q == StHi));
            sram_dq_o  = in_hi ? wdat_q[31:16] : wdat_q[15:0];
            sram_ub_n  = in_hi ? ~sel_q[3] : ~sel_q[1];
            sram_lb_n  = in_hi ? ~sel_q[2] : ~sel_q[0];
         end else begin
            sram_oe_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: SRAM behavioural model, reference memory and an
// ack scoreboard holding expected data and latency for every accepted request.
module tb_wb_sram_slave;

   localparam int unsigned ADDR_W      = 20;
   localparam int unsigned WAIT_STATES = 1;
`ifdef WB_SRAM_LANE_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              bus_cyc = 1'b0, bus_stb = 1'b0, bus_we = 1'b0;
   logic [3:0]        bus_sel = '0;
   logic [31:0]       bus_adr = '0, bus_dat_i = '0;
   logic [31:0]       bus_dat_o;
   logic              bus_ack, bus_stall;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_o, sram_dq_i;
   logic              sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   always #5 clk_i = ~clk_i;

   wb_sram_slave #(
      .ADDR_W      (ADDR_W),
      .WAIT_STATES (WAIT_STATES)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bus_cyc    (bus_cyc),
      .bus_stb    (bus_stb),
      .bus_we     (bus_we),
      .bus_sel    (bus_sel),
      .bus_adr    (bus_adr),
      .bus_dat_i  (bus_dat_i),
      .bus_dat_o  (bus_dat_o),
      .bus_ack    (bus_ack),
      .bus_stall  (bus_stall),
      .sram_addr  (sram_addr),
      .sram_dq_o  (sram_dq_o),
      .sram_dq_i  (sram_dq_i),
      .sram_dq_oe (sram_dq_oe),
      .sram_ce_n  (sram_ce_n),
      .sram_oe_n  (sram_oe_n),
      .sram_we_n  (sram_we_n),
      .sram_ub_n  (sram_ub_n),
      .sram_lb_n  (sram_lb_n)
   );

   // SRAM model driven by the DUT strobes; ref_mem is what the bench believes should be stored
   logic [15:0] mem     [0:(1<<ADDR_W)-1];
   logic [15:0] ref_mem [0:(1<<ADDR_W)-1];

   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

   always @(posedge clk_i) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq_o[15:8];
         if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq_o[7:0];
      end
   end

   typedef struct {
      logic [31:0] dat;
      int          lat;
      time         t_acc;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   time  last_acc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic we, input logic [3:0] sel);
      int l;
      l = 1;
      if (!(SKIP && sel[1:0] == 2'b00)) l += int'(WAIT_STATES) + 1 + (we ? 1 : 0);
      if (!(SKIP && sel[3:2] == 2'b00)) l += int'(WAIT_STATES) + 1 + (we ? 1 : 0);
      return l;
   endfunction

   // Ack monitor: every ack must match the oldest outstanding expectation
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i && bus_ack) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_ack", 32'(bus_ack), 32'd0);
         end else begin
            e = sb.pop_front();
            check_eq({e.tag, "_dat"}, bus_dat_o, e.dat);
            check_eq({e.tag, "_lat"}, 32'(($time - e.t_acc + 5) / 10), 32'(e.lat));
            check_eq({e.tag, "_stall_in_ack"}, 32'(bus_stall), 32'd1);
         end
      end
   end

   task automatic wb_req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input string tag);
      exp_t              e;
      int                guard;
      logic [ADDR_W-1:0] h0, h1;
      logic              lo_acc, hi_acc;
      @(negedge clk_i);
      bus_cyc   = 1'b1;
      bus_stb   = 1'b1;
      bus_we    = we;
      bus_sel   = sel;
      bus_adr   = adr;
      bus_dat_i = dat;
      guard     = 0;
      while (bus_stall && guard < 100) begin
         @(negedge clk_i);
         guard++;
      end
      if (guard >= 100) begin
         check_eq({tag, "_accept_timeout"}, 32'(bus_stall), 32'd0);
         bus_stb = 1'b0;
         return;
      end
      @(posedge clk_i);
      last_acc = $time;
      h0       = {adr[ADDR_W:2], 1'b0};
      h1       = {adr[ADDR_W:2], 1'b1};
      lo_acc   = !(SKIP && sel[1:0] == 2'b00);
      hi_acc   = !(SKIP && sel[3:2] == 2'b00);
      e.tag    = tag;
      e.t_acc  = $time;
      e.lat    = exp_lat(we, sel);
      if (we) begin
         e.dat = 32'h0;
         if (sel[0]) ref_mem[h0][7:0]  = dat[7:0];
         if (sel[1]) ref_mem[h0][15:8] = dat[15:8];
         if (sel[2]) ref_mem[h1][7:0]  = dat[23:16];
         if (sel[3]) ref_mem[h1][15:8] = dat[31:24];
      end else begin
         e.dat = {hi_acc ? ref_mem[h1] : 16'h0, lo_acc ? ref_mem[h0] : 16'h0};
      end
      sb.push_back(e);
      #1 bus_stb = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 200) begin
         @(negedge clk_i);
         guard++;
      end
      if (guard >= 200) begin
         check_eq("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      @(negedge clk_i);
      bus_cyc = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached with %0d requests outstanding", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      time t_a;
      int  guard;
      for (int i = 0; i < 128; i++) begin
         mem[i]     = 16'h1000 + 16'(i * 16'h0111);
         ref_mem[i] = mem[i];
      end
      mem[8] = 16'hBEEF; ref_mem[8] = 16'hBEEF;
      mem[9] = 16'hDEAD; ref_mem[9] = 16'hDEAD;
      mem[2] = 16'hAAAA; ref_mem[2] = 16'hAAAA;
      mem[3] = 16'h5555; ref_mem[3] = 16'h5555;

      // Reset state
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_eq("rst_ack_stall", {30'd0, bus_ack, bus_stall}, 32'd0);
      check_eq("rst_dat_o", bus_dat_o, 32'd0);
      check_eq("rst_strobes", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                               sram_dq_oe}, 32'h3E);
      check_eq("rst_addr_dq", {sram_addr, sram_dq_o}, '0);
      rst_i = 1'b0;

      // Basic read: halfword sequence and stall profile
      wb_req(1'b0, 4'hF, 32'h10, 32'h0, "rd1");
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk_i);
         check_eq($sformatf("rd1_addr_c%0d", i), 32'(sram_addr), (i <= 2) ? 32'h8 : 32'h9);
         check_eq($sformatf("rd1_stall_ack_c%0d", i), {30'd0, bus_stall, bus_ack}, 32'h2);
      end
      wait_idle();
      check_eq("rd1_hold_dat_o", bus_dat_o, 32'hDEADBEEF);

      // Single-byte write into upper half
      wb_req(1'b1, 4'b0100, 32'h4, 32'h12345678, "wr1");
`ifndef WB_SRAM_LANE_SKIP_EN
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk_i);
         check_eq($sformatf("wr1_we_n_c%0d", i), 32'(sram_we_n), (i == 3 || i == 6) ? 32'd1 : 32'd0);
         if (i == 1) check_eq("wr1_lo_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'h3);
         if (i == 4) begin
            check_eq("wr1_hi_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'h2);
            check_eq("wr1_hi_dq", {15'd0, sram_dq_oe, sram_dq_o}, 32'h0001_1234);
         end
      end
`endif
      wait_idle();
      check_eq("wr1_mem_hw3", 32'(mem[3]), 32'h5534);
      check_eq("wr1_mem_hw2", 32'(mem[2]), 32'hAAAA);

      // Back-to-back: second request held during stall, accepted right after the ack
      wb_req(1'b0, 4'hF, 32'h20, 32'h0, "b2b_a");
      t_a = last_acc;
      wb_req(1'b1, 4'b1001, 32'h24, 32'hA1B2C3D4, "b2b_b");
      check_eq("b2b_accept_gap", 32'((last_acc - t_a) / 10), 32'(exp_lat(1'b0, 4'hF) + 1));
      wb_req(1'b0, 4'hF, 32'h24, 32'h0, "b2b_c");
      wait_idle();

      // Address wrap above ADDR_W+1
      wb_req(1'b0, 4'hF, 32'hFFE0_0010, 32'h0, "wrap");
      @(negedge clk_i);
      check_eq("wrap_addr", 32'(sram_addr), 32'h8);
      wait_idle();

      // Partial-lane reads
      wb_req(1'b0, 4'b0011, 32'h10, 32'h0, "rd_lo");
      wait_idle();
      wb_req(1'b0, 4'b0000, 32'h10, 32'h0, "rd_none");
      wait_idle();

      // Abort during HI of a read
      wb_req(1'b0, 4'hF, 32'h30, 32'h0, "abort");
      guard = 0;
      do begin
         @(negedge clk_i);
         guard++;
      end while (sram_addr != 20'h19 && guard < 20);
      check_eq("abort_reach_hi", 32'(sram_addr), 32'h19);
      bus_cyc = 1'b0;
      void'(sb.pop_back());
      @(negedge clk_i);
      check_eq("abort_strobes", {29'd0, sram_ce_n, sram_oe_n, bus_stall}, 32'h6);
      check_eq("abort_no_ack", 32'(bus_ack), 32'd0);
      wb_req(1'b0, 4'hF, 32'h30, 32'h0, "after_abort");
      wait_idle();

      // Reset during LO_REC of a write
      wb_req(1'b1, 4'hF, 32'h40, 32'hCAFEF00D, "rst_wr");
      guard = 0;
      do begin
         @(negedge clk_i);
         guard++;
      end while (!(sram_we_n && !sram_ce_n) && guard < 20);
      check_eq("rst_wr_reach_rec", {30'd0, sram_we_n, sram_ce_n}, 32'h2);
      rst_i = 1'b1;
      void'(sb.pop_back());
      @(negedge clk_i);
      check_eq("rst_wr_strobes", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
                                  sram_dq_oe}, 32'h3E);
      check_eq("rst_wr_ack_stall", {30'd0, bus_ack, bus_stall}, 32'd0);
      rst_i   = 1'b0;
      bus_cyc = 1'b0;

      // Random pipelined traffic over a small window so reads hit earlier writes
      for (int i = 0; i < 24; i++) begin
         wb_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                32'h80 + 32'($urandom_range(0, 7)) * 32'd4, $urandom, $sformatf("rnd%0d", i));
      end
      wait_idle();
      for (int i = 0; i < 8; i++) begin
         wb_req(1'b0, 4'hF, 32'h80 + 32'(i) * 32'd4, 32'h0, $sformatf("rdback%0d", i));
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Wishbone pipelined-mode responder (slave end of the if_wb bus) driving an external asynchronous 16-bit SRAM.
- Sits behind one master port of the address-decoding interconnect, e.g. the SDRAM/RAM window, as a low-cost external-memory target.
- Splits each 32-bit Wishbone access into two sequenced 16-bit SRAM cycles with programmable wait states.
- Returns one ack per accepted request.

Parameters:
- ADDR_W, 20: SRAM halfword address width; the block decodes bus.adr[ADDR_W:2].
- WAIT_STATES, 1: extra cycles per SRAM access beyond the first; legal range 0..15.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- bus  if_wb.slave  -  Wishbone bus.
  - Inputs: cyc, stb, we, sel[3:0], adr[31:0], dat_i[31:0].
  - Outputs: dat_o[31:0], ack, stall.
- sram_addr  out  ADDR_W  halfword address.
- sram_dq_o  out  16  write data.
- sram_dq_i  in  16  read data.
- sram_dq_oe  out  1  data bus output enable; the top-level tristate uses it.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_ub_n  out  1  upper byte lane enable, active-low.
- sram_lb_n  out  1  lower byte lane enable, active-low.

Behaviour:
- Reset (rst_i high at clk edge):
  - State goes to IDLE.
  - ack=0, stall=0, dat_o=0.
  - ce_n=oe_n=we_n=ub_n=lb_n=1, dq_oe=0, sram_addr=0, dq_o=0.
  - Reset takes effect immediately mid-access; no ack is issued for the aborted request.
- States: IDLE, LO, LO_REC, HI, HI_REC, ACK.
- stall=1 in every state except IDLE.
- Accept: in IDLE, cyc&stb high at a clock edge.
  - Latch adr, we, sel, dat_i.
  - Load wait counter = WAIT_STATES.
  - Go to LO.
- LO / HI, one SRAM access each:
  - sram_addr = {adr[ADDR_W:2], 0} for LO, {adr[ADDR_W:2], 1} for HI.
  - LO carries bits 15:0 with lanes sel[1:0]; HI carries bits 31:16 with lanes sel[3:2].
  - ce_n=0 throughout.
  - Read: oe_n=0, ub_n=lb_n=0.
  - Write: we_n=0, dq_oe=1, dq_o = latched half, ub_n/lb_n = ~sel lanes.
  - Each state lasts WAIT_STATES+1 cycles; the counter decrements and the state exits when the counter is 0.
  - Read data is captured from sram_dq_i into the matching dat_o half on the exiting edge.
- Transitions:
  - Read: LO -> HI -> ACK.
  - Write: LO -> LO_REC -> HI -> HI_REC -> ACK.
- REC states last 1 cycle: we_n=1, ce_n=0, dq_oe=1, address and data held (write hold time).
- ACK: ack=1 for exactly one cycle, dat_o valid; next state IDLE. stall=1 here, so no accept is possible in ACK.
- Latency, accept edge to ack-high cycle:
  - Read: 2*(WAIT_STATES+1)+1.
  - Write: 2*(WAIT_STATES+1)+3.
  - With WAIT_STATES=1: read 5, write 7.
- dat_o:
  - Cleared to 0 on accept.
  - Holds its last value after ack.
  - Write acks present 0.
- Abort: cyc low in any non-IDLE state.
  - Next edge goes to IDLE.
  - All SRAM strobes deasserted, no ack.
  - A write is aborted mid-pulse; this is accepted behaviour.
- stb while stall=1 is ignored; the master must hold it.
- Address bits above ADDR_W+1 are ignored.
  - The SRAM wraps modulo 2^(ADDR_W+1) bytes.

Optional Feature:
- Macro: WB_SRAM_LANE_SKIP_EN.
- Defined:
  - A half whose sel lanes are both 0 is skipped entirely; no SRAM cycle and no REC state.
  - The skipped half of dat_o reads 0.
  - sel=4'b0000 goes accept -> ACK, so ack comes 1 cycle after accept.
  - sel=4'b0011 read latency is WAIT_STATES+2.
- Undefined: both halves are always accessed regardless of sel, with the timing given above.

Test Plan:
- Read, WAIT_STATES=1: adr=0x00000010, sel=F; SRAM model holds hw 0x8=0xBEEF, 0x9=0xDEAD.
  - sram_addr=0x8 for 2 cycles, then 0x9 for 2 cycles.
  - ack high exactly 5 cycles after accept, dat_o=0xDEADBEEF.
  - stall=1 from the cycle after accept through the ack cycle.
- Write adr=0x4, sel=4'b0100, dat_i=0x12345678.
  - Two we_n pulses of 2 cycles each.
  - LO pulse: ub_n=lb_n=1. HI pulse: lb_n=0, ub_n=1, dq_o=0x1234.
  - ack 7 cycles after accept.
  - Model shows only byte 0x34 written, at hw 0x3 lower lane.
- Back-to-back: a second request presented during stall is held by the master.
  - Accepted in the first IDLE cycle after ack.
  - No lost or duplicated ack.
- Abort: drop cyc during HI of a read.
  - Next cycle: ce_n=oe_n=1, stall=0, no ack.
  - A following read completes normally.
- Reset: assert rst_i during LO_REC of a write.
  - After the edge: all strobes high, dq_oe=0, ack=0, stall=0.
- With WB_SRAM_LANE_SKIP_EN:
  - Read sel=4'b0011 -> only hw 0x8 accessed, ack at cycle 3, dat_o[31:16]=0.
  - sel=0 -> ack 1 cycle after accept, no SRAM activity.
